// File: rtl/sort_lane_scheduler_if.sv
// Bundle between the two scale lanes, the shared package_sort datapath and the result consumer.
// master is the environment side (lanes, sorter, consumer); slave is the scheduler.
interface sort_lane_scheduler_if #(
  parameter int unsigned W = 12
);
  logic [W-1:0] a_weight;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] b_weight;
  logic         b_valid;
  logic         b_ready;
  logic [W-1:0] sort_weight;
  logic [2:0]   grp_in;
  logic         res_valid;
  logic         res_lane;
  logic [2:0]   res_grp;
  logic         drop;
  logic [7:0]   a_cnt;
  logic [7:0]   b_cnt;
  logic         busy;

  modport master (
    output a_weight, a_valid, b_weight, b_valid, grp_in,
    input  a_ready, b_ready, sort_weight, res_valid, res_lane, res_grp, drop, a_cnt, b_cnt, busy
  );

  modport slave (
    input  a_weight, a_valid, b_weight, b_valid, grp_in,
    output a_ready, b_ready, sort_weight, res_valid, res_lane, res_grp, drop, a_cnt, b_cnt, busy
  );
endinterface

// File: rtl/sort_lane_scheduler.sv
// Time-shares one package_sort datapath between lanes A and B: round-robin grant, one framed
// weight pulse per package, lane-tagged group result and saturating per-lane package counts.
module sort_lane_scheduler #(
  parameter int unsigned W        = 12,
  parameter int unsigned HOLD_CYC = 1,
  parameter int unsigned GAP_CYC  = 1
) (
  input logic                  clk,
  input logic                  reset,
  sort_lane_scheduler_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StDrive, StCapture, StGap} state_e;

  localparam int unsigned CntMax = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYC - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    weight_q, weight_d;
  logic            lane_q, lane_d;
  logic            last_q, last_d;
  logic            drop_q, drop_d;
  logic            res_valid_q, res_valid_d;
  logic            res_lane_q, res_lane_d;
  logic [2:0]      res_grp_q, res_grp_d;
  logic [7:0]      a_cnt_q, a_cnt_d;
  logic [7:0]      b_cnt_q, b_cnt_d;

  logic         idle;
  logic         grant_a, grant_b;
  logic         xfer;
  logic [W-1:0] xfer_weight;

  // Readys are gated by reset too so they read 0 while reset is held.
  assign idle        = (state_q == StIdle);
  assign grant_a     = reset & idle & bus.a_valid & (~bus.b_valid | last_q);
  assign grant_b     = reset & idle & bus.b_valid & (~bus.a_valid | ~last_q);
  assign xfer        = grant_a | grant_b;
  assign xfer_weight = grant_b ? bus.b_weight : bus.a_weight;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    weight_d    = weight_q;
    lane_d      = lane_q;
    last_d      = last_q;
    drop_d      = 1'b0;
    res_valid_d = 1'b0;
    res_lane_d  = res_lane_q;
    res_grp_d   = res_grp_q;
    a_cnt_d     = a_cnt_q;
    b_cnt_d     = b_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          last_d = grant_b;
          if (xfer_weight == '0) begin
            drop_d = 1'b1;
          end else begin
            weight_d = xfer_weight;
            lane_d   = grant_b;
            cnt_d    = HoldLast;
            state_d  = StDrive;
          end
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StCapture: begin
        // Sorter output is stable by now since the weight bus has already returned to 0.
        res_valid_d = 1'b1;
        res_lane_d  = lane_q;
        res_grp_d   = bus.grp_in;
        if (lane_q) begin
          b_cnt_d = (b_cnt_q == 8'hff) ? b_cnt_q : b_cnt_q + 8'd1;
        end else begin
          a_cnt_d = (a_cnt_q == 8'hff) ? a_cnt_q : a_cnt_q + 8'd1;
        end
        cnt_d   = GapLast;
        state_d = StGap;
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      weight_q    <= '0;
      lane_q      <= 1'b0;
      last_q      <= 1'b1;
      drop_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_lane_q  <= 1'b0;
      res_grp_q   <= '0;
      a_cnt_q     <= '0;
      b_cnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      weight_q    <= weight_d;
      lane_q      <= lane_d;
      last_q      <= last_d;
      drop_q      <= drop_d;
      res_valid_q <= res_valid_d;
      res_lane_q  <= res_lane_d;
      res_grp_q   <= res_grp_d;
      a_cnt_q     <= a_cnt_d;
      b_cnt_q     <= b_cnt_d;
    end
  end

  assign bus.a_ready     = grant_a;
  assign bus.b_ready     = grant_b;
  assign bus.sort_weight = (state_q == StDrive) ? weight_q : '0;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_lane    = res_lane_q;
  assign bus.res_grp     = res_grp_q;
  assign bus.drop        = drop_q;
  assign bus.a_cnt       = a_cnt_q;
  assign bus.b_cnt       = b_cnt_q;
  assign bus.busy        = ~idle;

endmodule

// File: tb/tb_sort_lane_scheduler.sv
// Bench for sort_lane_scheduler: directed vector table, reset/saturation sequences and random
// traffic on two parameterisations, each checked every cycle against a timeline model.
module tb_sort_lane_scheduler;
  localparam int unsigned W = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         a_valid = 1'b0, b_valid = 1'b0;
  logic [W-1:0] a_weight = '0, b_weight = '0;
  logic [2:0]   grp = '0;

  sort_lane_scheduler_if #(.W(W)) if0 ();
  sort_lane_scheduler_if #(.W(W)) if1 ();

  assign if0.a_valid = a_valid;  assign if1.a_valid = a_valid;
  assign if0.b_valid = b_valid;  assign if1.b_valid = b_valid;
  assign if0.a_weight = a_weight; assign if1.a_weight = a_weight;
  assign if0.b_weight = b_weight; assign if1.b_weight = b_weight;
  assign if0.grp_in = grp;       assign if1.grp_in = grp;

  sort_lane_scheduler #(.W(W), .HOLD_CYC(1), .GAP_CYC(1)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave)
  );
  sort_lane_scheduler #(.W(W), .HOLD_CYC(3), .GAP_CYC(2)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave)
  );

  typedef struct packed {
    logic ar; logic br; logic [W-1:0] sw; logic rv; logic rl; logic [2:0] rg;
    logic drop; logic busy; logic [7:0] ac; logic [7:0] bc;
  } obs_t;

  typedef struct packed {
    logic av; logic [W-1:0] aw; logic bv; logic [W-1:0] bw; logic [2:0] g; obs_t exp;
  } vec_t;

  int checks = 0, errors = 0, cyc = 0;
  bit mon_en = 1'b0;

  function automatic obs_t get_obs(input int d);
    if (d == 0)
      return {if0.a_ready, if0.b_ready, if0.sort_weight, if0.res_valid, if0.res_lane,
              if0.res_grp, if0.drop, if0.busy, if0.a_cnt, if0.b_cnt};
    return {if1.a_ready, if1.b_ready, if1.sort_weight, if1.res_valid, if1.res_lane,
            if1.res_grp, if1.drop, if1.busy, if1.a_cnt, if1.b_cnt};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Model: each package is a set of absolute cycle numbers derived from its handshake cycle.
  int hold_c[2] = '{1, 3};
  int gap_c[2]  = '{1, 2};
  int m_idle_at[2], m_sw_from[2], m_sw_to[2], m_cap_at[2], m_res_at[2], m_drop_at[2];
  int m_acnt[2], m_bcnt[2];
  logic [W-1:0] m_w[2];
  logic         m_lane[2], m_last[2], m_rl[2];
  logic [2:0]   m_cap[2], m_rg[2];

  task automatic model_reset(input int d);
    m_idle_at[d] = 0; m_sw_from[d] = -1; m_sw_to[d] = -2; m_cap_at[d] = -1;
    m_res_at[d] = -1; m_drop_at[d] = -1; m_acnt[d] = 0; m_bcnt[d] = 0;
    m_w[d] = '0; m_lane[d] = 1'b0; m_last[d] = 1'b1; m_rl[d] = 1'b0;
    m_cap[d] = '0; m_rg[d] = '0;
  endtask

  task automatic model_step(input int d, output obs_t e);
    bit idle, ga, gb;
    logic [W-1:0] w;
    e = '0;
    if (!reset) begin
      model_reset(d);
      return;
    end
    if (cyc == m_res_at[d]) begin
      m_rl[d] = m_lane[d];
      m_rg[d] = m_cap[d];
      if (m_lane[d]) m_bcnt[d] = (m_bcnt[d] >= 255) ? 255 : m_bcnt[d] + 1;
      else           m_acnt[d] = (m_acnt[d] >= 255) ? 255 : m_acnt[d] + 1;
    end
    idle = (cyc >= m_idle_at[d]);
    ga = idle && a_valid && (!b_valid || m_last[d]);
    gb = idle && b_valid && (!a_valid || !m_last[d]);
    e.ar = ga; e.br = gb;
    e.sw = (cyc >= m_sw_from[d] && cyc <= m_sw_to[d]) ? m_w[d] : '0;
    e.rv = (cyc == m_res_at[d]);
    e.rl = m_rl[d]; e.rg = m_rg[d];
    e.drop = (cyc == m_drop_at[d]);
    e.busy = !idle;
    e.ac = 8'(m_acnt[d]); e.bc = 8'(m_bcnt[d]);
    if (cyc == m_cap_at[d]) m_cap[d] = grp;
    if (ga || gb) begin
      w = gb ? b_weight : a_weight;
      m_last[d] = gb;
      if (w == '0) m_drop_at[d] = cyc + 1;
      else begin
        m_lane[d] = gb; m_w[d] = w;
        m_sw_from[d] = cyc + 1;
        m_sw_to[d]   = cyc + hold_c[d];
        m_cap_at[d]  = cyc + hold_c[d] + 1;
        m_res_at[d]  = cyc + hold_c[d] + 2;
        m_idle_at[d] = cyc + hold_c[d] + gap_c[d] + 2;
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    obs_t e, g;
    if (mon_en) begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
        model_step(d, e);
        g = get_obs(d);
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL model dut%0d cyc %0d got %h expected %h", d, cyc, g, e);
        end
      end
    end
  end

  function automatic vec_t v(input bit av, input int aw, input bit bv, input int bw, input int g,
                             input bit ar, input bit br, input int sw, input bit rv, input bit rl,
                             input int rg, input bit dr, input bit bz, input int ac, input int bc);
    vec_t r;
    r.av = av; r.aw = W'(aw); r.bv = bv; r.bw = W'(bw); r.g = 3'(g);
    r.exp = {ar, br, W'(sw), rv, rl, 3'(rg), dr, bz, 8'(ac), 8'(bc)};
    return r;
  endfunction

  vec_t tbl[$];

  task automatic set_in(input bit av, input int aw, input bit bv, input int bw, input int g);
    a_valid = av; a_weight = W'(aw); b_valid = bv; b_weight = W'(bw); grp = 3'(g);
  endtask

  initial begin
    int n0, n1;
    bit seen;
    obs_t g;
    // av aw bv bw grp | ar br sw rv rl rg drop busy acnt bcnt   (HOLD=1, GAP=1)
    tbl.push_back(v(1, 270, 0, 0,    0, 1, 0, 0,    0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 999, 0, 0,    0, 0, 0, 270,  0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 999, 0, 0,    2, 0, 0, 0,    0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0,   0, 0,    5, 0, 0, 0,    1, 0, 2, 0, 1, 1, 0));
    tbl.push_back(v(0, 0,   1, 0,    5, 0, 1, 0,    0, 0, 2, 0, 0, 1, 0));
    tbl.push_back(v(1, 501, 1, 1013, 3, 1, 0, 0,    0, 0, 2, 1, 0, 1, 0));
    tbl.push_back(v(1, 501, 1, 1013, 3, 0, 0, 501,  0, 0, 2, 0, 1, 1, 0));
    tbl.push_back(v(1, 501, 1, 1013, 3, 0, 0, 0,    0, 0, 2, 0, 1, 1, 0));
    tbl.push_back(v(1, 501, 1, 1013, 1, 0, 0, 0,    1, 0, 3, 0, 1, 2, 0));
    tbl.push_back(v(1, 501, 1, 1013, 4, 0, 1, 0,    0, 0, 3, 0, 0, 2, 0));
    tbl.push_back(v(1, 501, 1, 1013, 4, 0, 0, 1013, 0, 0, 3, 0, 1, 2, 0));
    tbl.push_back(v(1, 501, 1, 1013, 4, 0, 0, 0,    0, 0, 3, 0, 1, 2, 0));
    tbl.push_back(v(1, 501, 1, 1013, 1, 0, 0, 0,    1, 1, 4, 0, 1, 2, 1));
    tbl.push_back(v(1, 501, 1, 1013, 7, 1, 0, 0,    0, 1, 4, 0, 0, 2, 1));
    tbl.push_back(v(1, 501, 1, 1013, 7, 0, 0, 501,  0, 1, 4, 0, 1, 2, 1));
    tbl.push_back(v(1, 501, 1, 1013, 7, 0, 0, 0,    0, 1, 4, 0, 1, 2, 1));
    tbl.push_back(v(1, 501, 1, 1013, 2, 0, 0, 0,    1, 0, 7, 0, 1, 3, 1));
    tbl.push_back(v(1, 501, 1, 1013, 0, 0, 1, 0,    0, 0, 7, 0, 0, 3, 1));
    tbl.push_back(v(0, 0,   0, 0,    0, 0, 0, 1013, 0, 0, 7, 0, 1, 3, 1));
    tbl.push_back(v(0, 0,   0, 0,    0, 0, 0, 0,    0, 0, 7, 0, 1, 3, 1));
    tbl.push_back(v(0, 0,   0, 0,    6, 0, 0, 0,    1, 1, 0, 0, 1, 3, 2));
    tbl.push_back(v(0, 0,   0, 0,    0, 0, 0, 0,    0, 1, 0, 0, 0, 3, 2));

    // Reset held with a request pending.
    #1 reset = 1'b0;
    mon_en = 1'b1;
    set_in(1, 123, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_a_ready", int'(if0.a_ready), 0);
    chk("rst_b_ready", int'(if0.b_ready), 0);
    chk("rst_sort_weight", int'(if0.sort_weight), 0);
    chk("rst_a_cnt", int'(if0.a_cnt), 0);
    chk("rst_b_cnt", int'(if0.b_cnt), 0);

    // Directed vectors; row 0 is the first cycle after release.
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) reset = 1'b1;
      set_in(tbl[i].av, int'(tbl[i].aw), tbl[i].bv, int'(tbl[i].bw), int'(tbl[i].g));
      @(negedge clk);
      g = get_obs(0);
      checks++;
      if (g !== tbl[i].exp) begin
        errors++;
        $display("FAIL vec%0d got %h expected %h", i, g, tbl[i].exp);
      end
    end

    // Reset asserted in the middle of a DRIVE cycle.
    @(posedge clk); #1 set_in(1, 300, 0, 0, 0);
    @(posedge clk); #1 set_in(0, 0, 0, 0, 0);
    chk("drive_sw_before_rst", int'(if0.sort_weight), 300);
    #1 reset = 1'b0;
    #1 chk("rst_async_sw", int'(if0.sort_weight), 0);
    chk("rst_async_busy", int'(if0.busy), 0);
    @(posedge clk); #1 reset = 1'b1;
    n0 = 0;
    repeat (5) begin
      @(negedge clk);
      n0 += int'(if0.res_valid);
    end
    chk("rst_no_res", n0, 0);
    chk("rst_a_cnt_after", int'(if0.a_cnt), 0);
    @(posedge clk); #1 set_in(1, 300, 0, 0, 3);
    @(posedge clk); #1 set_in(0, 0, 0, 0, 3);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (if0.res_valid) seen = 1'b1;
    end
    chk("recover_res_seen", int'(seen), 1);
    chk("recover_res_lane", int'(if0.res_lane), 0);
    chk("recover_res_grp", int'(if0.res_grp), 3);
    chk("recover_a_cnt", int'(if0.a_cnt), 1);

    // Lane B only: pulse length per parameterisation, then counter saturation.
    @(posedge clk); #1 reset = 1'b0; set_in(0, 0, 0, 0, 0);
    @(posedge clk); #1 reset = 1'b1; set_in(0, 0, 1, 77, 0);
    n0 = 0; n1 = 0;
    repeat (7) begin
      @(negedge clk);
      n0 += int'(if0.sort_weight == W'(77));
      n1 += int'(if1.sort_weight == W'(77));
    end
    chk("hold1_pulses", n0, 2);
    chk("hold3_cycles", n1, 3);
    repeat (1900) begin
      @(posedge clk); #1;
      b_weight = W'($urandom_range(1, (1 << W) - 1));
      grp = 3'($urandom);
    end
    @(negedge clk);
    chk("sat_b_cnt0", int'(if0.b_cnt), 255);
    chk("sat_a_cnt0", int'(if0.a_cnt), 0);
    chk("sat_b_cnt1", int'(if1.b_cnt), 255);
    chk("sat_a_cnt1", int'(if1.a_cnt), 0);

    // Random traffic with occasional resets; the monitor checks every cycle.
    repeat (3000) begin
      @(posedge clk); #1;
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset = 1'b0;
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 3) != 0);
      a_weight = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      b_weight = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      grp = 3'($urandom);
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
